// File: rtl/pcie_disp_pkg.sv
// pcie_disp_pkg: shared DispVal bit map, default widths, schedule sentinel and entry record.
//   DISP_*      : bit positions inside the DispVal control word (bits 15..9 reserved, zero)
//   *_DEF       : default widths/depth used by the sequencer and its table
//   SENTINEL    : trigger value marking an unused schedule slot (all ones)
//   disp_entry_t: one schedule entry {trigger cycle, display word}
package pcie_disp_pkg;

    localparam int DISP_FINISH    = 0;
    localparam int DISP_STOP      = 1;
    localparam int DISP_ALL       = 2;
    localparam int DISP_PL        = 3;
    localparam int DISP_DL        = 4;
    localparam int DISP_TL        = 5;
    localparam int DISP_RAWSYM    = 6;
    localparam int DISP_SWNOHDR   = 7;
    localparam int DISP_LINKEVENT = 8;

    localparam int DISP_W_DEF = 16;
    localparam int CNT_W_DEF  = 32;
    localparam int DEPTH_DEF  = 16;

    localparam logic [CNT_W_DEF-1:0] SENTINEL = '1;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]  cycle;
        logic [DISP_W_DEF-1:0] val;
    } disp_entry_t;

endpackage

// File: rtl/cont_disps_table.sv
// cont_disps_table: schedule storage with one write port and one combinational read port.
//   Clk, Reset               : clock, asynchronous active-high clear (cycles -> all ones, vals -> 0)
//   wr_en/wr_addr/wr_cycle/wr_val : entry write at the rising edge
//   rd_addr -> rd_cycle/rd_val    : combinational read of one entry
module cont_disps_table
    import pcie_disp_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DISP_W = DISP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [CNT_W-1:0]         wr_cycle,
    input  logic [DISP_W-1:0]        wr_val,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [CNT_W-1:0]         rd_cycle,
    output logic [DISP_W-1:0]        rd_val
);

    logic [CNT_W-1:0]  cycles [DEPTH];
    logic [DISP_W-1:0] vals   [DEPTH];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cycles[i] <= '1;
                vals[i]   <= '0;
            end
        end else if (wr_en) begin
            cycles[wr_addr] <= wr_cycle;
            vals[wr_addr]   <= wr_val;
        end
    end

    assign rd_cycle = cycles[rd_addr];
    assign rd_val   = vals[rd_addr];

endmodule

// File: rtl/cont_disps.sv
// cont_disps: display-control sequencer applying a loaded {cycle, word} schedule against a cycle counter.
//   Clk, Reset                    : clock, asynchronous active-high reset
//   LdEn/LdAddr/LdCycle/LdVal     : schedule entry write
//   DispVal                       : current display control word
//   StopReq, FinishReq            : one-cycle pulses from the applied word's STOP/FINISH bits
//   Count                         : saturating cycle counter
//   Done                          : sticky, schedule exhausted
module cont_disps
    import pcie_disp_pkg::*;
#(
    parameter int                DISP_W     = DISP_W_DEF,
    parameter int                CNT_W      = CNT_W_DEF,
    parameter int                DEPTH      = DEPTH_DEF,
    parameter logic [DISP_W-1:0] DISP_RESET = '0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     LdEn,
    input  logic [$clog2(DEPTH)-1:0] LdAddr,
    input  logic [CNT_W-1:0]         LdCycle,
    input  logic [DISP_W-1:0]        LdVal,
    output logic [DISP_W-1:0]        DispVal,
    output logic                     StopReq,
    output logic                     FinishReq,
    output logic [CNT_W-1:0]         Count,
    output logic                     Done
);

    localparam int              AW   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] SENT = '1;

    logic [AW:0]       idx;
    logic [CNT_W-1:0]  cur_cycle;
    logic [DISP_W-1:0] cur_val;
    logic              at_end;
    logic              apply;
    logic              term_q;

    cont_disps_table #(
        .CNT_W (CNT_W),
        .DISP_W(DISP_W),
        .DEPTH (DEPTH)
    ) u_table (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (LdEn),
        .wr_addr (LdAddr),
        .wr_cycle(LdCycle),
        .wr_val  (LdVal),
        .rd_addr (idx[AW-1:0]),
        .rd_cycle(cur_cycle),
        .rd_val  (cur_val)
    );

    assign at_end = idx[AW] || cur_cycle == SENT;
    assign apply  = !at_end && Count >= cur_cycle;

    // The terminal condition must hold on two consecutive cycles before Done latches,
    // so a schedule whose first entry is written on the first edge after reset is not
    // declared finished by the still-empty table.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Count     <= '0;
            idx       <= '0;
            DispVal   <= DISP_RESET;
            StopReq   <= 1'b0;
            FinishReq <= 1'b0;
            term_q    <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Count     <= Count == SENT - CNT_W'(1) ? Count : Count + CNT_W'(1);
            StopReq   <= apply && cur_val[DISP_STOP];
            FinishReq <= apply && cur_val[DISP_FINISH];
            term_q    <= at_end;
            Done      <= Done || (term_q && at_end);
            if (apply) begin
                DispVal <= cur_val;
                idx     <= idx + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_cont_disps.sv
// tb_cont_disps: self-checking bench for cont_disps (directed table, corner sequences, random schedules).
module tb_cont_disps;
    import pcie_disp_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_cycle = '0;
    logic [15:0] ld_val = '0;
    logic [15:0] disp;
    logic        stop, fin, done;
    logic [31:0] cnt;

    logic        ld_en2 = 1'b0;
    logic [1:0]  ld_addr2 = '0;
    logic [3:0]  ld_cycle2 = '0;
    logic [15:0] ld_val2 = '0;
    logic [15:0] disp2;
    logic        stop2, fin2, done2;
    logic [3:0]  cnt2;

    int n_pass = 0;
    int n_tot  = 0;
    int c      = 0;
    int n_ld   = 0;
    int ld_i   = 0;
    logic [31:0] sch_c [DEPTH];
    logic [15:0] sch_v [DEPTH];

    typedef struct {
        int          c;
        logic [15:0] disp;
        logic        stop;
        logic        fin;
        logic        done;
    } vec_t;
    vec_t vecs [13];

    always #5 clk = ~clk;

    cont_disps dut (
        .Clk(clk), .Reset(rst), .LdEn(ld_en), .LdAddr(ld_addr), .LdCycle(ld_cycle), .LdVal(ld_val),
        .DispVal(disp), .StopReq(stop), .FinishReq(fin), .Count(cnt), .Done(done)
    );

    cont_disps #(.CNT_W(4), .DEPTH(4)) dut_small (
        .Clk(clk), .Reset(rst), .LdEn(ld_en2), .LdAddr(ld_addr2), .LdCycle(ld_cycle2), .LdVal(ld_val2),
        .DispVal(disp2), .StopReq(stop2), .FinishReq(fin2), .Count(cnt2), .Done(done2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at count %0d: got %0h want %0h", name, c, act, exp);
    endtask

    task automatic drive_load();
        if (ld_i < n_ld) begin
            ld_en    = 1'b1;
            ld_addr  = 4'(ld_i);
            ld_cycle = sch_c[ld_i];
            ld_val   = sch_v[ld_i];
        end else begin
            ld_en = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c++;
        ld_i++;
        drive_load();
    endtask

    // Reset, check the reset state, then release with entry 0 already presented
    // so it is written on the first edge after release.
    task automatic start_run();
        rst  = 1'b1;
        ld_i = 0;
        drive_load();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", cnt, 0);
        chk("rst_disp", disp, 0);
        chk("rst_stop", stop, 0);
        chk("rst_fin", fin, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        c   = 0;
    endtask

    // Reference: entry k takes effect at cycle a[k] = max(trigger, a[k-1]+1); its word is
    // visible from a[k]+1; the schedule end is seen at cycle e and Done from e+2.
    task automatic check_run(input int c_end, input bit use_end);
        int          a [DEPTH];
        int          e;
        logic [15:0] ed;
        logic        es, ef;
        for (int k = 0; k < n_ld; k++)
            a[k] = (k == 0 || int'(sch_c[k]) > a[k-1] + 1) ? int'(sch_c[k]) : a[k-1] + 1;
        e = (n_ld == 0) ? 0 : a[n_ld-1] + 1;
        if (use_end) c_end = e + 4;
        while (c <= c_end) begin
            ed = 16'h0;
            es = 1'b0;
            ef = 1'b0;
            for (int k = 0; k < n_ld; k++) begin
                if (a[k] <= c - 1) ed = sch_v[k];
                if (a[k] == c - 1) begin
                    es = sch_v[k][DISP_STOP];
                    ef = sch_v[k][DISP_FINISH];
                end
            end
            chk("count", cnt, 64'(c));
            chk("disp", disp, ed);
            chk("stop", stop, es);
            chk("fin", fin, ef);
            chk("done", done, c >= e + 2);
            step();
        end
    endtask

    task automatic load_directed();
        n_ld = 6;
        sch_c[0] = 5;  sch_v[0] = 16'h0008;
        sch_c[1] = 5;  sch_v[1] = 16'h0010;
        sch_c[2] = 7;  sch_v[2] = 16'h0002;
        sch_c[3] = 9;  sch_v[3] = 16'h0001;
        sch_c[4] = 10; sch_v[4] = 16'h0004;
        sch_c[5] = 20; sch_v[5] = 16'h0018;
    endtask

    initial begin
        int t;
        vecs = '{
            '{0,  16'h0000, 1'b0, 1'b0, 1'b0},
            '{5,  16'h0000, 1'b0, 1'b0, 1'b0},
            '{6,  16'h0008, 1'b0, 1'b0, 1'b0},
            '{7,  16'h0010, 1'b0, 1'b0, 1'b0},
            '{8,  16'h0002, 1'b1, 1'b0, 1'b0},
            '{9,  16'h0002, 1'b0, 1'b0, 1'b0},
            '{10, 16'h0001, 1'b0, 1'b1, 1'b0},
            '{11, 16'h0004, 1'b0, 1'b0, 1'b0},
            '{20, 16'h0004, 1'b0, 1'b0, 1'b0},
            '{21, 16'h0018, 1'b0, 1'b0, 1'b0},
            '{22, 16'h0018, 1'b0, 1'b0, 1'b0},
            '{23, 16'h0018, 1'b0, 1'b0, 1'b1},
            '{30, 16'h0018, 1'b0, 1'b0, 1'b1}
        };

        load_directed();
        start_run();
        foreach (vecs[i]) begin
            while (c < vecs[i].c) step();
            chk("tbl_count", cnt, 64'(c));
            chk("tbl_disp", disp, vecs[i].disp);
            chk("tbl_stop", stop, vecs[i].stop);
            chk("tbl_fin", fin, vecs[i].fin);
            chk("tbl_done", done, vecs[i].done);
        end

        load_directed();
        start_run();
        while (c < 15) step();
        chk("pre_rst_disp", disp, 16'h0004);
        rst      = 1'b1;
        ld_en    = 1'b1;
        ld_addr  = 4'd0;
        ld_cycle = 32'd2;
        ld_val   = 16'h0040;
        #1;
        chk("async_rst_count", cnt, 0);
        chk("async_rst_disp", disp, 0);
        chk("async_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        ld_en = 1'b0;
        n_ld  = 0;
        ld_i  = 0;
        rst   = 1'b0;
        c     = 0;
        check_run(49, 1'b0);
        chk("sat_count", cnt2, 14);
        chk("small_done", done2, 1);
        chk("small_disp", disp2, 0);
        chk("small_pulses", {stop2, fin2}, 0);

        ld_en    = 1'b1;
        ld_addr  = 4'd0;
        ld_cycle = 32'd3;
        ld_val   = 16'h0020;
        step();
        chk("late_count", cnt, 51);
        chk("late_disp_before", disp, 0);
        step();
        chk("late_disp_after", disp, 16'h0020);
        chk("late_done_sticky", done, 1);

        for (int it = 0; it < 6; it++) begin
            n_ld = (it == 0) ? DEPTH : int'($urandom_range(0, DEPTH));
            t = 20;
            for (int k = 0; k < n_ld; k++) begin
                t += int'($urandom_range(0, 3));
                sch_c[k] = 32'(t);
                sch_v[k] = 16'($urandom) & 16'h01FF;
            end
            start_run();
            check_run(0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
